// File: rtl/demux_1x4_reg.sv
// Registered 1-to-4 demultiplexer: steers i onto y0..y3 by {s1,s0}, zeroing the rest.
// Optional macro DEMUX_ACTIVE_OH_EN adds a registered one-hot select output 'act'.
module demux_1x4_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i,
  input  logic             s1,
  input  logic             s0,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3
`ifdef DEMUX_ACTIVE_OH_EN
  ,
  output logic [3:0]       act
`endif
);

  logic [1:0]       sel;
  logic [3:0]       sel_oh;
  logic [WIDTH-1:0] y_next [4];
  logic [WIDTH-1:0] y_reg  [4];

  assign sel = {s1, s0};

  // Each lane decodes its own equality compare, so any resolved select value
  // enables at most one lane and the outputs stay one-hot-or-zero.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign sel_oh[gi] = (sel == 2'(gi));
      assign y_next[gi] = sel_oh[gi] ? i : '0;

      always_ff @(posedge clk) begin
        if (rst) begin
          y_reg[gi] <= '0;
        end else begin
          y_reg[gi] <= y_next[gi];
        end
      end
    end
  endgenerate

  assign y0 = y_reg[0];
  assign y1 = y_reg[1];
  assign y2 = y_reg[2];
  assign y3 = y_reg[3];

`ifdef DEMUX_ACTIVE_OH_EN
  logic [3:0] act_reg;

  // Tracks the select alone, independent of the data value.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_reg <= 4'b0000;
    end else begin
      act_reg <= sel_oh;
    end
  end

  assign act = act_reg;
`endif

endmodule

// File: tb/tb_demux_1x4_reg.sv
// Directed bench for demux_1x4_reg: one WIDTH=1 and one WIDTH=8 instance on a shared clock/reset.
module tb_demux_1x4_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic       i1, s1_a, s0_a;
  logic [7:0] i8;
  logic       s1_b, s0_b;
  logic       y0_a, y1_a, y2_a, y3_a;
  logic [7:0] y0_b, y1_b, y2_b, y3_b;
`ifdef DEMUX_ACTIVE_OH_EN
  logic [3:0] act_a, act_b;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  demux_1x4_reg #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .i(i1), .s1(s1_a), .s0(s0_a),
    .y0(y0_a), .y1(y1_a), .y2(y2_a), .y3(y3_a)
`ifdef DEMUX_ACTIVE_OH_EN
    , .act(act_a)
`endif
  );

  demux_1x4_reg #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .i(i8), .s1(s1_b), .s0(s0_b),
    .y0(y0_b), .y1(y1_b), .y2(y2_b), .y3(y3_b)
`ifdef DEMUX_ACTIVE_OH_EN
    , .act(act_b)
`endif
  );

  // Expected y vector packed as {y3,y2,y1,y0}.
  task automatic chk1(input string tag, input logic [3:0] exp_y);
    logic [3:0] obs;
    obs = {y3_a, y2_a, y1_a, y0_a};
    checks++;
    assert (obs === exp_y) else begin
      errors++;
      $error("FAIL %s: y3..y0 observed %b expected %b", tag, obs, exp_y);
    end
    $display("t=%0t %s: y3..y0=%b expected %b", $time, tag, obs, exp_y);
  endtask

  task automatic chk8(input string tag, input logic [31:0] exp_y);
    logic [31:0] obs;
    obs = {y3_b, y2_b, y1_b, y0_b};
    checks++;
    assert (obs === exp_y) else begin
      errors++;
      $error("FAIL %s: y3..y0 observed %h expected %h", tag, obs, exp_y);
    end
    $display("t=%0t %s: y3..y0=%h expected %h", $time, tag, obs, exp_y);
  endtask

`ifdef DEMUX_ACTIVE_OH_EN
  task automatic chk_act(input string tag, input logic [3:0] exp_a, input logic [3:0] exp_b);
    checks++;
    assert (act_a === exp_a) else begin
      errors++;
      $error("FAIL %s act(w1): observed %b expected %b", tag, act_a, exp_a);
    end
    checks++;
    assert (act_b === exp_b) else begin
      errors++;
      $error("FAIL %s act(w8): observed %b expected %b", tag, act_b, exp_b);
    end
  endtask
`endif

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held for two edges with non-zero data and select 11.
    rst = 1'b1; i1 = 1'b1; {s1_a, s0_a} = 2'b11;
    i8 = 8'hFF; {s1_b, s0_b} = 2'b11;
    tick; chk1("rst_edge1", 4'b0000); chk8("rst8_edge1", 32'h0);
`ifdef DEMUX_ACTIVE_OH_EN
    chk_act("rst_edge1", 4'b0000, 4'b0000);
`endif
    tick; chk1("rst_edge2", 4'b0000); chk8("rst8_edge2", 32'h0);
`ifdef DEMUX_ACTIVE_OH_EN
    chk_act("rst_edge2", 4'b0000, 4'b0000);
`endif

    // Basic routing.
    rst = 1'b0; i1 = 1'b1; {s1_a, s0_a} = 2'b00;
    i8 = 8'hA5; {s1_b, s0_b} = 2'b10;
    tick; chk1("sel00_i1", 4'b0001); chk8("w8_sel10_A5", 32'h00A5_0000);
`ifdef DEMUX_ACTIVE_OH_EN
    chk_act("sel00", 4'b0001, 4'b0100);
`endif

    i1 = 1'b0; {s1_a, s0_a} = 2'b01;
    i8 = 8'h3C; {s1_b, s0_b} = 2'b01;
    tick; chk1("sel01_i0", 4'b0000); chk8("w8_sel01_3C", 32'h0000_3C00);
`ifdef DEMUX_ACTIVE_OH_EN
    chk_act("sel01_i0", 4'b0010, 4'b0010);
`endif

    i1 = 1'b1; {s1_a, s0_a} = 2'b10;
    i8 = 8'h00; {s1_b, s0_b} = 2'b11;
    tick; chk1("sel10_i1", 4'b0100); chk8("w8_sel11_00", 32'h0);
`ifdef DEMUX_ACTIVE_OH_EN
    chk_act("sel10", 4'b0100, 4'b1000);
`endif

    i1 = 1'b1; {s1_a, s0_a} = 2'b11;
    i8 = 8'h81; {s1_b, s0_b} = 2'b00;
    tick; chk1("sel11_i1", 4'b1000); chk8("w8_sel00_81", 32'h0000_0081);

    // Mid-cycle reset pulse must not disturb outputs (reset is sampled only at edges).
    rst = 1'b1;
    #2; chk1("midcycle_rst_hold", 4'b1000); chk8("w8_midcycle_rst_hold", 32'h0000_0081);
    rst = 1'b0;
    tick; chk1("after_mid_rst", 4'b1000); chk8("w8_after_mid_rst", 32'h0000_0081);

    // Reset asserted together with a new select: reset wins.
    rst = 1'b1; {s1_a, s0_a} = 2'b00; i1 = 1'b1;
    i8 = 8'hA5; {s1_b, s0_b} = 2'b10;
    tick; chk1("rst_priority", 4'b0000); chk8("w8_rst_priority", 32'h0);
`ifdef DEMUX_ACTIVE_OH_EN
    chk_act("rst_priority", 4'b0000, 4'b0000);
`endif

    // Back-to-back select sweep, data and select changing every cycle.
    rst = 1'b0; i1 = 1'b1;
    {s1_a, s0_a} = 2'b00; i8 = 8'h11; {s1_b, s0_b} = 2'b00;
    tick; chk1("b2b_00", 4'b0001); chk8("w8_b2b_00", 32'h0000_0011);
    {s1_a, s0_a} = 2'b01; i8 = 8'h22; {s1_b, s0_b} = 2'b01;
    tick; chk1("b2b_01", 4'b0010); chk8("w8_b2b_01", 32'h0000_2200);
    {s1_a, s0_a} = 2'b10; i8 = 8'h44; {s1_b, s0_b} = 2'b10;
    tick; chk1("b2b_10", 4'b0100); chk8("w8_b2b_10", 32'h0044_0000);
    {s1_a, s0_a} = 2'b11; i8 = 8'h88; {s1_b, s0_b} = 2'b11;
    tick; chk1("b2b_11", 4'b1000); chk8("w8_b2b_11", 32'h8800_0000);
`ifdef DEMUX_ACTIVE_OH_EN
    chk_act("b2b_11", 4'b1000, 4'b1000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
